// File: rtl/pb_key_event.sv
// Turns a debounced button level into PRESS / REPEAT / RELEASE events
// delivered through a 2-entry valid/ready queue; overflow flags lost PRESS/RELEASE.
module pb_key_event #(
    parameter int LONG_MS   = 500,
    parameter int REPEAT_MS = 100,
    parameter int CNT_W     = 16
) (
    input  logic       clk_1ms,
    input  logic       rst_n,
    input  logic       pbreg,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_code,
    output logic       held,
    output logic       overflow
);

    localparam logic [1:0] EV_NONE    = 2'b00;
    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_REPEAT  = 2'b10;
    localparam logic [1:0] EV_RELEASE = 2'b11;

    typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             pb_q_reg;
    logic             held_reg;
    logic             overflow_reg;
    logic [1:0]       q_reg [2];
    logic [1:0]       occ_reg;

    logic       rise;
    logic       fall;
    logic       long_hit;
    logic       rpt_hit;
    logic [1:0] gen_code;
    logic       pop;
    logic [1:0] occ_after;
    logic       push;
    logic       lost;

    assign rise     = pbreg & ~pb_q_reg;
    assign fall     = ~pbreg & pb_q_reg;
    assign long_hit = (cnt_reg == CNT_W'(LONG_MS - 1));
    assign rpt_hit  = (cnt_reg == CNT_W'(REPEAT_MS - 1));

    // A fall always wins over a threshold hit in the same cycle.
    always_comb begin
        gen_code = EV_NONE;
        case (state_reg)
            IDLE:    if (rise) gen_code = EV_PRESS;
            HOLD:    if (fall) gen_code = EV_RELEASE;
                     else if (long_hit) gen_code = EV_REPEAT;
            RPT:     if (fall) gen_code = EV_RELEASE;
                     else if (rpt_hit) gen_code = EV_REPEAT;
            default: gen_code = EV_NONE;
        endcase
    end

    // Occupancy is judged after this cycle's pop; REPEATs only land in an empty queue.
    assign pop       = (occ_reg != 2'd0) & evt_ready;
    assign occ_after = occ_reg - 2'(pop);
    assign push      = ((gen_code == EV_REPEAT) && (occ_after == 2'd0)) ||
                       (((gen_code == EV_PRESS) || (gen_code == EV_RELEASE)) && (occ_after != 2'd2));
    assign lost      = ((gen_code == EV_PRESS) || (gen_code == EV_RELEASE)) && (occ_after == 2'd2);

    always_ff @(posedge clk_1ms) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            pb_q_reg  <= 1'b0;
            held_reg  <= 1'b0;
        end else begin
            pb_q_reg <= pbreg;
            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        state_reg <= HOLD;
                        cnt_reg   <= '0;
                        held_reg  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (fall) begin
                        state_reg <= IDLE;
                        held_reg  <= 1'b0;
                    end else if (long_hit) begin
                        state_reg <= RPT;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RPT: begin
                    if (fall) begin
                        state_reg <= IDLE;
                        held_reg  <= 1'b0;
                    end else if (rpt_hit) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    held_reg  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_1ms) begin
        if (!rst_n) begin
            occ_reg      <= 2'd0;
            q_reg[0]     <= EV_NONE;
            q_reg[1]     <= EV_NONE;
            overflow_reg <= 1'b0;
        end else begin
            occ_reg <= occ_after + 2'(push);
            if (pop)
                q_reg[0] <= q_reg[1];
            // Later assignment wins when a pop and a push into the head coincide.
            if (push) begin
                if (occ_after == 2'd0)
                    q_reg[0] <= gen_code;
                else
                    q_reg[1] <= gen_code;
            end
            if (lost)
                overflow_reg <= 1'b1;
        end
    end

    assign evt_valid = (occ_reg != 2'd0);
    assign evt_code  = evt_valid ? q_reg[0] : EV_NONE;
    assign held      = held_reg;
    assign overflow  = overflow_reg;

endmodule
